// File: rtl/multicycle_cpu_if.sv
// ----------------------------------------------------------------------------
// multicycle_cpu_if
// Memory-side bus of the multicycle core: one instruction-fetch channel and
// one data channel. Each channel uses a req/ack handshake, and the requester
// holds req until it sees ack.
//   imem_req   : fetch request              (master -> slave)
//   imem_addr  : fetch byte address (PC)    (master -> slave)
//   imem_rdata : instruction word           (slave -> master), valid with ack
//   imem_ack   : fetch complete             (slave -> master)
//   dmem_req   : data access request        (master -> slave)
//   dmem_we    : 1 = store, 0 = load        (master -> slave)
//   dmem_addr  : data byte address          (master -> slave)
//   dmem_wdata : store data                 (master -> slave)
//   dmem_rdata : load data                  (slave -> master), valid with ack
//   dmem_ack   : data access complete       (slave -> master)
// ----------------------------------------------------------------------------
interface multicycle_cpu_if #(
   parameter int XLEN = 64
);
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic [31:0]     imem_rdata;
   logic            imem_ack;
   logic            dmem_req;
   logic            dmem_we;
   logic [XLEN-1:0] dmem_addr;
   logic [XLEN-1:0] dmem_wdata;
   logic [XLEN-1:0] dmem_rdata;
   logic            dmem_ack;

   modport master (
      output imem_req, imem_addr,
      input  imem_rdata, imem_ack,
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_rdata, dmem_ack
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_rdata, imem_ack,
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_rdata, dmem_ack
   );
endinterface

// File: rtl/multicycle_cpu.sv
// ----------------------------------------------------------------------------
// multicycle_cpu
// Small multicycle core for an ARMv8-like subset: ADD, SUB, AND, ORR, LDUR,
// STUR, CBZ, B, plus HALT (the all-zero instruction word). Each instruction
// steps through FETCH -> DECODE -> EXEC -> (MEM) -> (WB). The core stops in
// HALT until reset.
// Ports:
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset
//   bus     : instruction/data memory bus (multicycle_cpu_if.master)
//   halted  : high once the core has decoded HALT
//   illegal : one-cycle pulse after an undecodable opcode is skipped
// Parameters:
//   XLEN : datapath, register and PC width
//   NREG : register count. The index field is always 5 bits. Indices at or
//          above NREG, and index 31, read as zero and ignore writes.
// ----------------------------------------------------------------------------
module multicycle_cpu #(
   parameter int XLEN = 64,
   parameter int NREG = 32
) (
   input  logic             clk,
   input  logic             rst,
   multicycle_cpu_if.master bus,
   output logic             halted,
   output logic             illegal
);
   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   localparam logic [10:0]     OP_ADD  = 11'b10001011000;
   localparam logic [10:0]     OP_SUB  = 11'b11001011000;
   localparam logic [10:0]     OP_AND  = 11'b10001010000;
   localparam logic [10:0]     OP_ORR  = 11'b10101010000;
   localparam logic [10:0]     OP_LDUR = 11'b11111000010;
   localparam logic [10:0]     OP_STUR = 11'b11111000000;
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [31:0]     ir_q, ir_d;
   logic [XLEN-1:0] a_q, a_d;
   logic [XLEN-1:0] b_q, b_d;
   logic [XLEN-1:0] alu_q, alu_d;
   logic [XLEN-1:0] mdr_q, mdr_d;
   logic            halted_q, halted_d;
   logic            illegal_q, illegal_d;

   logic [XLEN-1:0] rf_q [NREG];
   logic            rf_we;
   logic [XLEN-1:0] rf_wdata;
   logic [4:0]      rf_waddr;
   logic [XLEN-1:0] rn_val, rm_val, rt_val;

   // Instruction decode from the latched IR.
   logic [10:0] opcode;
   logic        is_add, is_sub, is_and, is_orr, is_ldur, is_stur;
   logic        is_cbz, is_b, is_rtype, is_mem;

   assign opcode   = ir_q[31:21];
   assign is_add   = (opcode == OP_ADD);
   assign is_sub   = (opcode == OP_SUB);
   assign is_and   = (opcode == OP_AND);
   assign is_orr   = (opcode == OP_ORR);
   assign is_ldur  = (opcode == OP_LDUR);
   assign is_stur  = (opcode == OP_STUR);
   assign is_cbz   = (ir_q[31:24] == 8'b10110100);
   assign is_b     = (ir_q[31:26] == 6'b000101);
   assign is_rtype = is_add | is_sub | is_and | is_orr;
   assign is_mem   = is_ldur | is_stur;

   // Sign-extended immediates. The branch offsets count words, so they are
   // scaled to bytes here.
   logic [XLEN-1:0] mem_off, cbz_off, br_off;
   assign mem_off = {{(XLEN-9){ir_q[20]}}, ir_q[20:12]};
   assign cbz_off = {{(XLEN-21){ir_q[23]}}, ir_q[23:5], 2'b00};
   assign br_off  = {{(XLEN-28){ir_q[25]}}, ir_q[25:0], 2'b00};

   // Register-file read ports. Index 31 and out-of-range indices yield zero.
   always_comb begin
      rn_val = '0;
      rm_val = '0;
      rt_val = '0;
      for (int i = 0; i < NREG; i++) begin
         if (ir_q[9:5]   == 5'(i)) rn_val = rf_q[i];
         if (ir_q[20:16] == 5'(i)) rm_val = rf_q[i];
         if (ir_q[4:0]   == 5'(i)) rt_val = rf_q[i];
      end
      if (ir_q[9:5]   == 5'd31) rn_val = '0;
      if (ir_q[20:16] == 5'd31) rm_val = '0;
      if (ir_q[4:0]   == 5'd31) rt_val = '0;
   end

   logic [XLEN-1:0] alu_res;
   always_comb begin
      alu_res = a_q + b_q;
      if (is_sub)      alu_res = a_q - b_q;
      else if (is_and) alu_res = a_q & b_q;
      else if (is_orr) alu_res = a_q | b_q;
   end

   assign rf_waddr = ir_q[4:0];

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      a_d       = a_q;
      b_d       = b_q;
      alu_d     = alu_q;
      mdr_d     = mdr_q;
      halted_d  = halted_q;
      illegal_d = 1'b0;
      rf_we     = 1'b0;
      rf_wdata  = alu_q;
      case (state_q)
         S_FETCH: begin
            if (bus.imem_ack) begin
               ir_d    = bus.imem_rdata;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            a_d = rn_val;
            b_d = is_rtype ? rm_val : rt_val;
            if (ir_q == 32'h0) begin
               halted_d = 1'b1;
               state_d  = S_HALT;
            end else if (is_rtype || is_mem || is_cbz || is_b) begin
               state_d = S_EXEC;
            end else begin
               // Skip the undecodable word and flag it for one cycle.
               illegal_d = 1'b1;
               pc_d      = pc_q + PC_STEP;
               state_d   = S_FETCH;
            end
         end
         S_EXEC: begin
            if (is_rtype) begin
               alu_d   = alu_res;
               state_d = S_WB;
            end else if (is_mem) begin
               alu_d   = a_q + mem_off;
               state_d = S_MEM;
            end else if (is_cbz) begin
               pc_d    = (b_q == '0) ? pc_q + cbz_off : pc_q + PC_STEP;
               state_d = S_FETCH;
            end else begin
               pc_d    = pc_q + br_off;
               state_d = S_FETCH;
            end
         end
         S_MEM: begin
            if (bus.dmem_ack) begin
               if (is_stur) begin
                  pc_d    = pc_q + PC_STEP;
                  state_d = S_FETCH;
               end else begin
                  mdr_d   = bus.dmem_rdata;
                  state_d = S_WB;
               end
            end
         end
         S_WB: begin
            rf_we    = 1'b1;
            rf_wdata = is_ldur ? mdr_q : alu_q;
            pc_d     = pc_q + PC_STEP;
            state_d  = S_FETCH;
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_FETCH;
         pc_q      <= '0;
         ir_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         alu_q     <= '0;
         mdr_q     <= '0;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         a_q       <= a_d;
         b_q       <= b_d;
         alu_q     <= alu_d;
         mdr_q     <= mdr_d;
         halted_q  <= halted_d;
         illegal_q <= illegal_d;
      end
   end

   // Register 31 is never written, so it stays at its reset value of zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (rf_we && rf_waddr == 5'(i) && rf_waddr != 5'd31) rf_q[i] <= rf_wdata;
         end
      end
   end

   // The requests are decoded straight from the state register. This makes
   // the first fetch request appear right after reset is released. Gating
   // with rst makes a reset that arrives mid-access drop the request at once.
   assign bus.imem_req   = (state_q == S_FETCH) && !rst;
   assign bus.imem_addr  = pc_q;
   assign bus.dmem_req   = (state_q == S_MEM) && !rst;
   assign bus.dmem_we    = (state_q == S_MEM) && !rst && is_stur;
   assign bus.dmem_addr  = alu_q;
   assign bus.dmem_wdata = b_q;
   assign halted         = halted_q;
   assign illegal        = illegal_q;
endmodule

// File: tb/tb_multicycle_cpu.sv
`timescale 1ns/1ps
module tb_multicycle_cpu;
   localparam int XLEN = 64;

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic halted, illegal;
   always #5 clk = ~clk;

   multicycle_cpu_if #(.XLEN(XLEN)) bus ();

   multicycle_cpu #(.XLEN(XLEN), .NREG(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .halted  (halted),
      .illegal (illegal)
   );

   // ---------------- memory model ----------------
   logic [31:0] imem [0:63];
   logic [63:0] dmem [0:15];
   logic        stray_en = 1'b1;
   logic        phase2   = 1'b0;
   logic        sb_en    = 1'b1;
   int          iw_cnt, dw_cnt, cyc;
   int          iw_need, dw_need;

   always_comb begin
      iw_need = (bus.imem_addr == 64'd44) ? 2 : 0;
      dw_need = phase2 ? 5 : ((bus.dmem_addr == 64'd16 && bus.dmem_we) ? 3 : 0);
   end

   // Acks are also raised while the matching request is low. The core must ignore them.
   assign bus.imem_rdata = imem[bus.imem_addr[7:2]];
   assign bus.imem_ack   = (bus.imem_req && (iw_cnt >= iw_need)) || (stray_en && !bus.imem_req);
   assign bus.dmem_rdata = dmem[bus.dmem_addr[6:3]];
   assign bus.dmem_ack   = (bus.dmem_req && (dw_cnt >= dw_need)) || (stray_en && !bus.dmem_req);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc    <= 0;
         iw_cnt <= 0;
         dw_cnt <= 0;
      end else begin
         cyc    <= cyc + 1;
         iw_cnt <= (bus.imem_req && !bus.imem_ack) ? iw_cnt + 1 : 0;
         dw_cnt <= (bus.dmem_req && !bus.dmem_ack) ? dw_cnt + 1 : 0;
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [63:0] addr;
      int          cyc;
   } fetch_t;
   typedef struct {
      logic        we;
      logic [63:0] addr;
      logic [63:0] data;
      int          cyc;
      int          len;
   } dacc_t;

   fetch_t fetch_q[$];
   dacc_t  dmem_q[$];
   int     ill_q[$];
   int     halt_q[$];
   int     n_pass = 0;
   int     n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      if (act !== exp) begin
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
         n_fail++;
      end else begin
         n_pass++;
      end
   endtask

   task automatic unexpected(input string name, input logic [63:0] val);
      $display("FAIL %s: unexpected event, value %0h, expected none", name, val);
      n_fail++;
   endtask

   task automatic exp_fetch(input logic [63:0] a, input int c);
      fetch_t e;
      e.addr = a;
      e.cyc  = c;
      fetch_q.push_back(e);
   endtask

   task automatic exp_dmem(input logic we, input logic [63:0] a, input logic [63:0] d,
                           input int c, input int len);
      dacc_t e;
      e.we   = we;
      e.addr = a;
      e.data = d;
      e.cyc  = c;
      e.len  = len;
      dmem_q.push_back(e);
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   initial begin : monitor
      fetch_t      fe;
      dacc_t       de;
      int          ic;
      int          d_len;
      logic        d_stable;
      logic        d_we0;
      logic [63:0] d_addr0, d_wdata0;
      logic        halted_prev;
      d_len       = 0;
      d_stable    = 1'b1;
      d_we0       = 1'b0;
      d_addr0     = '0;
      d_wdata0    = '0;
      halted_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst && sb_en) begin
            if (bus.imem_req || bus.dmem_req)
               check("req_excl", {63'd0, bus.imem_req & bus.dmem_req}, 64'd0);
            if (bus.imem_req && bus.imem_ack) begin
               $display("cyc %0d fetch pc=%0h word=%08h", cyc, bus.imem_addr, bus.imem_rdata);
               if (fetch_q.size() == 0) unexpected("fetch", bus.imem_addr);
               else begin
                  fe = fetch_q.pop_front();
                  check("fetch_pc", bus.imem_addr, fe.addr);
                  check("fetch_cyc", 64'(cyc), 64'(fe.cyc));
               end
            end
            if (bus.dmem_req) begin
               if (d_len == 0) begin
                  d_we0    = bus.dmem_we;
                  d_addr0  = bus.dmem_addr;
                  d_wdata0 = bus.dmem_wdata;
               end else if (bus.dmem_we !== d_we0 || bus.dmem_addr !== d_addr0 ||
                            bus.dmem_wdata !== d_wdata0) begin
                  d_stable = 1'b0;
               end
               d_len++;
               if (bus.dmem_ack) begin
                  $display("cyc %0d dmem we=%0d addr=%0h wdata=%0h rdata=%0h len=%0d",
                           cyc, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata, bus.dmem_rdata, d_len);
                  if (dmem_q.size() == 0) unexpected("dmem", bus.dmem_addr);
                  else begin
                     de = dmem_q.pop_front();
                     check("dmem_we", {63'd0, bus.dmem_we}, {63'd0, de.we});
                     check("dmem_addr", bus.dmem_addr, de.addr);
                     if (de.we) check("dmem_wdata", bus.dmem_wdata, de.data);
                     check("dmem_cyc", 64'(cyc), 64'(de.cyc));
                     check("dmem_len", 64'(d_len), 64'(de.len));
                     check("dmem_stable", {63'd0, d_stable}, 64'd1);
                  end
                  d_len    = 0;
                  d_stable = 1'b1;
               end
            end
            if (illegal) begin
               $display("cyc %0d illegal pulse", cyc);
               if (ill_q.size() == 0) unexpected("illegal", 64'(cyc));
               else begin
                  ic = ill_q.pop_front();
                  check("illegal_cyc", 64'(cyc), 64'(ic));
               end
            end
            if (halted && !halted_prev) begin
               $display("cyc %0d halted", cyc);
               if (halt_q.size() == 0) unexpected("halted", 64'(cyc));
               else begin
                  ic = halt_q.pop_front();
                  check("halt_cyc", 64'(cyc), 64'(ic));
               end
            end
            halted_prev = halted;
         end
      end
   end

   // ---------------- instruction encoders ----------------
   function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rm,
                                         input logic [4:0] rn, input logic [4:0] rd);
      return {op, rm, 6'b000000, rn, rd};
   endfunction
   function automatic logic [31:0] enc_m(input logic [10:0] op, input logic [8:0] imm,
                                         input logic [4:0] rn, input logic [4:0] rt);
      return {op, imm, 2'b00, rn, rt};
   endfunction
   function automatic logic [31:0] enc_cbz(input logic [18:0] imm, input logic [4:0] rt);
      return {8'b10110100, imm, rt};
   endfunction
   function automatic logic [31:0] enc_b(input logic [25:0] imm);
      return {6'b000101, imm};
   endfunction

   // ---------------- stimulus ----------------
   initial begin : stimulus
      for (int i = 0; i < 64; i++) imem[i] = 32'h0;
      for (int i = 0; i < 16; i++) dmem[i] = 64'h0;
      dmem[0] = 64'd1;
      dmem[1] = 64'd5;

      imem[0]  = enc_r(OP_ADD, 5'd31, 5'd31, 5'd1);     // X1 = 0
      imem[1]  = enc_m(OP_LDUR, 9'd8, 5'd31, 5'd2);     // X2 = mem[8] = 5
      imem[2]  = enc_r(OP_ADD, 5'd2, 5'd2, 5'd3);       // X3 = 10
      imem[3]  = enc_m(OP_STUR, 9'd16, 5'd31, 5'd3);    // mem[16] = 10 (3 wait)
      imem[4]  = enc_cbz(19'd5, 5'd3);                  // not taken
      imem[5]  = enc_m(OP_LDUR, 9'd0, 5'd31, 5'd1);     // X1 = 1
      imem[6]  = enc_r(OP_SUB, 5'd1, 5'd31, 5'd4);      // X4 = 0 - 1
      imem[7]  = enc_m(OP_STUR, 9'd24, 5'd31, 5'd4);
      imem[8]  = enc_r(OP_ADD, 5'd4, 5'd4, 5'd31);      // discarded
      imem[9]  = enc_m(OP_STUR, 9'd32, 5'd31, 5'd31);
      imem[10] = enc_r(OP_AND, 5'd3, 5'd4, 5'd5);       // X5 = 10
      imem[11] = enc_r(OP_ORR, 5'd1, 5'd3, 5'd6);       // X6 = 11 (fetch has 2 wait)
      imem[12] = enc_r(OP_ADD, 5'd1, 5'd4, 5'd7);       // X7 = wraps to 0
      imem[13] = enc_m(OP_STUR, 9'd40, 5'd31, 5'd5);
      imem[14] = enc_m(OP_STUR, 9'd48, 5'd31, 5'd6);
      imem[15] = enc_m(OP_STUR, 9'd56, 5'd31, 5'd7);
      imem[16] = 32'hFFE0_0000;                         // undecodable
      imem[17] = enc_b(26'd3);                          // 68 -> 80
      imem[20] = enc_b(26'd3);                          // 80 -> 92
      imem[21] = enc_b(26'd3);                          // 84 -> 96
      imem[23] = enc_cbz(19'h7FFFE, 5'd31);             // 92 -> 84
      // imem[24] stays 0: HALT at PC 96

      exp_fetch(64'd0, 0);   exp_fetch(64'd4, 4);   exp_fetch(64'd8, 9);
      exp_fetch(64'd12, 13); exp_fetch(64'd16, 20); exp_fetch(64'd20, 23);
      exp_fetch(64'd24, 28); exp_fetch(64'd28, 32); exp_fetch(64'd32, 36);
      exp_fetch(64'd36, 40); exp_fetch(64'd40, 44); exp_fetch(64'd44, 50);
      exp_fetch(64'd48, 54); exp_fetch(64'd52, 58); exp_fetch(64'd56, 62);
      exp_fetch(64'd60, 66); exp_fetch(64'd64, 70); exp_fetch(64'd68, 72);
      exp_fetch(64'd80, 75); exp_fetch(64'd92, 78); exp_fetch(64'd84, 81);
      exp_fetch(64'd96, 84);

      exp_dmem(1'b0, 64'd8,  64'd0,  7,  1);
      exp_dmem(1'b1, 64'd16, 64'd10, 19, 4);
      exp_dmem(1'b0, 64'd0,  64'd0,  26, 1);
      exp_dmem(1'b1, 64'd24, 64'hFFFF_FFFF_FFFF_FFFF, 35, 1);
      exp_dmem(1'b1, 64'd32, 64'd0,  43, 1);
      exp_dmem(1'b1, 64'd40, 64'd10, 61, 1);
      exp_dmem(1'b1, 64'd48, 64'd11, 65, 1);
      exp_dmem(1'b1, 64'd56, 64'd0,  69, 1);
      ill_q.push_back(72);
      halt_q.push_back(86);

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_imem_req", {63'd0, bus.imem_req}, 64'd0);
      check("rst_dmem_req", {63'd0, bus.dmem_req}, 64'd0);
      check("rst_dmem_we", {63'd0, bus.dmem_we}, 64'd0);
      check("rst_halted", {63'd0, halted}, 64'd0);
      check("rst_illegal", {63'd0, illegal}, 64'd0);
      check("rst_pc", bus.imem_addr, 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 200 && !halted; i++) @(negedge clk);
      check("halt_reached", {63'd0, halted}, 64'd1);
      repeat (20) @(negedge clk);
      check("halt_no_imem", {63'd0, bus.imem_req}, 64'd0);
      check("halt_no_dmem", {63'd0, bus.dmem_req}, 64'd0);
      check("halt_held", {63'd0, halted}, 64'd1);
      check("fetch_q_left", 64'(fetch_q.size()), 64'd0);
      check("dmem_q_left", 64'(dmem_q.size()), 64'd0);
      check("ill_q_left", 64'(ill_q.size()), 64'd0);
      check("halt_q_left", 64'(halt_q.size()), 64'd0);

      // Reset while a data access is pending
      @(posedge clk);
      #1;
      sb_en    = 1'b0;
      stray_en = 1'b0;
      phase2   = 1'b1;
      rst      = 1'b1;
      #1 check("rst2_halted", {63'd0, halted}, 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 30 && !bus.dmem_req; i++) @(negedge clk);
      check("mem_reached", {63'd0, bus.dmem_req}, 64'd1);
      @(posedge clk);
      #1;
      check("mid_mem_req", {63'd0, bus.dmem_req}, 64'd1);
      rst = 1'b1;
      #1;
      check("abort_dmem_req", {63'd0, bus.dmem_req}, 64'd0);
      check("abort_imem_req", {63'd0, bus.imem_req}, 64'd0);
      check("abort_pc", bus.imem_addr, 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("restart_imem_req", {63'd0, bus.imem_req}, 64'd1);
      check("restart_pc", bus.imem_addr, 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
      $finish;
   end
endmodule

// File: doc/multicycle_cpu.md
MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, meaning datapath, register and PC width.
REQ-002 The block SHALL have parameter NREG, default 32, meaning register count (power of two, 5-bit index field always used, indices >= NREG read 0 / write ignored).
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high: port clk  input  1  rising-edge clock.
REQ-004 The block SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 The block SHALL have port imem_req  output  1  instruction fetch request, held until imem_ack.
REQ-006 The block SHALL have port imem_addr  output  XLEN  fetch byte address (= PC).
REQ-007 The block SHALL have port imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-008 The block SHALL have port imem_ack  input  1  fetch complete (may assert in the same cycle as imem_req).
REQ-009 The block SHALL have port dmem_req  output  1  data access request, held until dmem_ack.
REQ-010 The block SHALL have port dmem_we  output  1  1=store, 0=load, stable while dmem_req=1.
REQ-011 The block SHALL have port dmem_addr  output  XLEN  data byte address.
REQ-012 The block SHALL have port dmem_wdata  output  XLEN  store data.
REQ-013 The block SHALL have port dmem_rdata  input  XLEN  load data, valid when dmem_ack=1.
REQ-014 The block SHALL have port dmem_ack  input  1  data access complete.
REQ-015 The block SHALL have port halted  output  1  core stopped on HALT.
REQ-016 The block SHALL have port illegal  output  1  one-cycle pulse on undecodable opcode.

Function
REQ-017 The FSM SHALL have states FETCH, DECODE, EXEC, MEM, WB, HALT; all transitions on rising clk.
REQ-018 FETCH: imem_req=1; on imem_ack latch IR<=imem_rdata, go DECODE; otherwise stay.
REQ-019 DECODE: read Rn=IR[9:5], Rm=IR[20:16] (R-type) or Rt=IR[4:0] (STUR/CBZ) into A/B latches; HALT word (32'h0) -> HALT; unknown opcode -> pulse illegal, PC+=4, go FETCH.
REQ-020 Supported opcodes: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, LDUR 11111000010, STUR 11111000000, CBZ IR[31:24]=10110100, B IR[31:26]=000101.
REQ-021 EXEC: R-type ALUOut<=A op B (modulo 2^XLEN, carry discarded) -> WB; LDUR/STUR ALUOut<=A+sext(IR[20:12]) -> MEM; CBZ: PC<=(Rt==0)?PC+(sext(IR[23:5])<<2):PC+4 -> FETCH; B: PC<=PC+(sext(IR[25:0])<<2) -> FETCH.
REQ-022 MEM: dmem_req=1, dmem_addr=ALUOut, dmem_wdata=B, dmem_we per opcode; on dmem_ack, load latches MDR<=dmem_rdata -> WB, store PC+=4 -> FETCH; otherwise stay.
REQ-023 WB: Rd=IR[4:0] <= ALUOut (R-type) or MDR (LDUR); PC+=4; go FETCH.
REQ-024 Register 31 SHALL read as zero and writes to it SHALL be discarded.
REQ-025 Cycle counts with zero-wait acks: R-type 4, LDUR 5, STUR 4, CBZ 3, B 3; each wait cycle adds exactly one.
REQ-026 PC arithmetic SHALL wrap modulo 2^XLEN; negative branch offsets supported.
REQ-027 Requests SHALL not be withdrawn before ack; imem_req and dmem_req SHALL never be high simultaneously.
REQ-028 HALT: halted=1, no requests, state held until rst.
REQ-029 A stray ack while the corresponding req=0 SHALL be ignored.

Reset
REQ-030 On rst=1, asynchronously: state=FETCH, PC=0, all registers and IR/A/B/ALUOut/MDR=0, halted=0, illegal=0, imem_req/dmem_req/dmem_we=0.
REQ-031 First imem_req SHALL assert in the first cycle after rst deasserts; rst mid-access aborts the request immediately.

Verification
REQ-032 Zero-wait memory, program ADD X1,X31,X31; LDUR X2,[X31,#8] (mem[8]=5); ADD X3,X2,X2 -> X3=10, total 13 cycles from reset release.
REQ-033 STUR X3,[X31,#16] with X3=10, dmem_ack delayed 3 cycles -> dmem_req/addr/wdata stable 4 cycles, mem[16]=10, PC advances 4.
REQ-034 CBZ X31,#-2 at PC=8 -> PC=0; CBZ X3 (X3=10) -> PC=PC+4.
REQ-035 SUB X4,X31,X1 with X1=1 -> X4=all ones (2^XLEN-1); ADD X31,X4,X4 -> X31 still reads 0.
REQ-036 Opcode 11111111111 -> illegal high exactly one cycle, PC+4; word 32'h0 -> halted=1, no further requests; rst asserted mid-MEM -> dmem_req drops same cycle, PC=0.
